reset_seq_ctrl: RTL and testbench
=================================

Name: reset_seq_ctrl

Overview:
- Sequences release of N reset domains after the top-level reset is released.
- Each domain's active-low reset is released in index order, 0 first. The next domain is released only once the current domain acknowledges ready.
- Supervises acknowledgements with a timeout and watches for ack loss during operation.
- Supports a software-requested full re-sequence. Sits between the board reset input and the per-block reset generators.

Parameters:
- N_DOM, 3, number of reset domains (>=1).
- HOLD_CYC, 2, cycles all domains stay in reset before domain 0 is released (>=1).
- ACK_TIMEOUT, 4, extra cycles allowed for a domain ack after its release (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- irstn  in  1  asynchronous active-low reset.
- sw_rst_req  in  1  single-cycle request to re-sequence all domains.
- dom_ack  in  N_DOM  per-domain ready acknowledge, level.
- dom_rstn  out  N_DOM  per-domain active-low reset, registered.
- all_ready  out  1  high when all domains are released and acked (RUN).
- fault  out  1  sticky error flag.
- fault_idx  out  max(1,$clog2(N_DOM))  domain index that caused the fault.
- state_o  out  2  current state: HOLD=0, RELEASE=1, RUN=2, FAULT=3.

Behaviour:
- One clock. Reset is asynchronous and active-low on irstn. All state is cleared immediately when irstn goes low, with no clock required.
- Reset values: state=HOLD, cnt=0, idx=0, dom_rstn=0, all_ready=0, fault=0, fault_idx=0.
- Internal signals:
  - cnt is wide enough to hold max(HOLD_CYC, ACK_TIMEOUT).
  - idx is the current domain index.
- All outputs are registered and change only on the clk edge, except for the async clear.
- sw_rst_req has priority over every other event in every state. On it:
  - state becomes HOLD; cnt and idx become 0.
  - dom_rstn becomes all 0; all_ready becomes 0.
  - fault and fault_idx are cleared.
- HOLD:
  - Each edge: if cnt==HOLD_CYC-1, go to RELEASE with cnt=0, idx=0, dom_rstn[0]=1. Otherwise cnt++.
  - dom_rstn[0] therefore rises on the HOLD_CYC-th edge after irstn deasserts.
- RELEASE:
  - Only dom_ack[idx] is sampled; acks of other domains are ignored.
  - dom_ack[idx]=1 with idx<N_DOM-1: idx++, dom_rstn[idx+1]=1, cnt=0.
  - dom_ack[idx]=1 with idx==N_DOM-1: go to RUN, all_ready=1.
  - No ack and cnt==ACK_TIMEOUT: go to FAULT; fault=1, fault_idx=idx, dom_rstn=0.
  - No ack otherwise: cnt++.
  - The earliest ack is sampled one edge after the matching dom_rstn bit rises.
  - Released domains stay released (dom_rstn bits are monotonic within a sequence).
- RUN:
  - all_ready=1 and dom_rstn all 1.
  - If any dom_ack bit is 0: go to FAULT; fault=1, fault_idx = lowest index with ack=0; dom_rstn=0; all_ready=0.
- FAULT:
  - All domains are held in reset and fault stays 1.
  - Exit only via sw_rst_req (to HOLD) or irstn.
- N_DOM=1: RELEASE goes straight to RUN on dom_ack[0].
- A sw_rst_req on the same edge as the final ack gives HOLD, not RUN.

Test Plan:
- N_DOM=3, HOLD_CYC=2, ACK_TIMEOUT=4, dom_ack=dom_rstn (loopback), release irstn before edge 1:
  - dom_rstn = 001 at edge 2, 011 at edge 3, 111 at edge 4.
  - all_ready=1 and state_o=2 at edge 5.
- Same config, dom_ack[1] tied 0:
  - idx=1 at edge 3.
  - FAULT at edge 8: fault=1, fault_idx=1, dom_rstn=000, state_o=3.
  - Stays there for 20 further cycles.
- From RUN, pulse sw_rst_req:
  - Next edge: dom_rstn=000, all_ready=0, state_o=0.
  - Full sequence repeats with the same edge offsets as scenario 1.
- From RUN, force dom_ack[2]=0 and dom_ack[0]=0 together:
  - Next edge: FAULT, fault_idx=0, dom_rstn=000.
  - A following sw_rst_req clears fault and gives state_o=0.
- Drop irstn mid-RELEASE (idx=1), asynchronously between edges:
  - All outputs are 0 before the next edge.
  - After re-release, sequencing restarts from HOLD with dom_rstn[0] at edge 2.
- Assert sw_rst_req on the same edge dom_ack[2] first arrives:
  - Result is HOLD (state_o=0, all_ready=0, dom_rstn=000); RUN is never entered.

Source files
------------

// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl
// Releases a set of reset domains one at a time after the board reset goes
// away. Each domain must acknowledge before the next one is released. The
// block times out slow acknowledgements and watches for an ack that drops
// once everything is running. A software request restarts the whole sequence.

module reset_seq_ctrl #(
   parameter int N_DOM       = 3,
   parameter int HOLD_CYC    = 2,
   parameter int ACK_TIMEOUT = 4,
   localparam int IDX_W      = (N_DOM > 1) ? $clog2(N_DOM) : 1
) (
   input  logic             clk,
   input  logic             irstn,
   input  logic             sw_rst_req,
   input  logic [N_DOM-1:0] dom_ack,
   output logic [N_DOM-1:0] dom_rstn,
   output logic             all_ready,
   output logic             fault,
   output logic [IDX_W-1:0] fault_idx,
   output logic [1:0]       state_o
);

   // The counter is shared by the initial hold and the ack timeout, so it
   // must reach whichever limit is larger.
   localparam int CNT_MAX = (HOLD_CYC > ACK_TIMEOUT) ? HOLD_CYC : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DOM - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_FAULT   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [N_DOM-1:0] dom_rstn_nxt;
   logic             all_ready_nxt;
   logic             fault_nxt;
   logic [IDX_W-1:0] fault_idx_nxt;

   logic             any_nack;
   logic [IDX_W-1:0] first_nack;

   // Find the lowest-numbered domain whose ack is missing, used to blame a
   // domain when an ack drops while running.
   always_comb begin
      first_nack = '0;
      for (int i = N_DOM - 1; i >= 0; i--) begin
         if (!dom_ack[i]) begin
            first_nack = IDX_W'(i);
         end
      end
   end

   assign any_nack = ~&dom_ack;

   // Next-state and next-output logic; the software request overrides
   // everything else, including an ack arriving on the same edge.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      idx_nxt       = idx;
      dom_rstn_nxt  = dom_rstn;
      all_ready_nxt = all_ready;
      fault_nxt     = fault;
      fault_idx_nxt = fault_idx;

      if (sw_rst_req) begin
         state_nxt     = ST_HOLD;
         cnt_nxt       = '0;
         idx_nxt       = '0;
         dom_rstn_nxt  = '0;
         all_ready_nxt = 1'b0;
         fault_nxt     = 1'b0;
         fault_idx_nxt = '0;
      end else begin
         case (state)
            ST_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state_nxt       = ST_RELEASE;
                  cnt_nxt         = '0;
                  idx_nxt         = '0;
                  dom_rstn_nxt[0] = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end

            ST_RELEASE: begin
               if (dom_ack[idx]) begin
                  if (idx == LAST_IDX) begin
                     state_nxt     = ST_RUN;
                     all_ready_nxt = 1'b1;
                  end else begin
                     idx_nxt               = idx + IDX_ONE;
                     dom_rstn_nxt[idx_nxt] = 1'b1;
                     cnt_nxt               = '0;
                  end
               end else if (cnt == ACK_LAST) begin
                  state_nxt     = ST_FAULT;
                  fault_nxt     = 1'b1;
                  fault_idx_nxt = idx;
                  dom_rstn_nxt  = '0;
                  all_ready_nxt = 1'b0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end

            ST_RUN: begin
               all_ready_nxt = 1'b1;
               dom_rstn_nxt  = '1;
               if (any_nack) begin
                  state_nxt     = ST_FAULT;
                  fault_nxt     = 1'b1;
                  fault_idx_nxt = first_nack;
                  dom_rstn_nxt  = '0;
                  all_ready_nxt = 1'b0;
               end
            end

            ST_FAULT: begin
               dom_rstn_nxt  = '0;
               all_ready_nxt = 1'b0;
               fault_nxt     = 1'b1;
            end

            default: begin
               state_nxt     = ST_HOLD;
               cnt_nxt       = '0;
               idx_nxt       = '0;
               dom_rstn_nxt  = '0;
               all_ready_nxt = 1'b0;
            end
         endcase
      end
   end

   // State and output registers, cleared immediately by the board reset.
   always_ff @(posedge clk or negedge irstn) begin
      if (!irstn) begin
         state     <= ST_HOLD;
         cnt       <= '0;
         idx       <= '0;
         dom_rstn  <= '0;
         all_ready <= 1'b0;
         fault     <= 1'b0;
         fault_idx <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         dom_rstn  <= dom_rstn_nxt;
         all_ready <= all_ready_nxt;
         fault     <= fault_nxt;
         fault_idx <= fault_idx_nxt;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb_reset_seq_ctrl
// Directed bench for reset_seq_ctrl (N_DOM=3, HOLD_CYC=2, ACK_TIMEOUT=4).
// Stimulus queues the expected output vector for a given clock edge; a
// negedge monitor pops and compares entries as their edge comes up.

module tb_reset_seq_ctrl;

   localparam int N_DOM       = 3;
   localparam int HOLD_CYC    = 2;
   localparam int ACK_TIMEOUT = 4;

   logic       clk = 1'b0;
   logic       irstn = 1'b0;
   logic       sw_rst_req = 1'b0;
   logic [2:0] dom_ack;
   logic [2:0] dom_rstn;
   logic       all_ready;
   logic       fault;
   logic [1:0] fault_idx;
   logic [1:0] state_o;

   logic       loopback = 1'b1;
   logic [2:0] ack_and = 3'b111;
   logic [2:0] ack_val = 3'b000;

   int edge_num = 0;
   int checks = 0;
   int passes = 0;
   logic flush_req = 1'b0;

   typedef struct {
      int         edge_n;
      logic [8:0] vec;
      string      name;
   } exp_t;

   exp_t exp_q[$];

   reset_seq_ctrl #(
      .N_DOM(N_DOM),
      .HOLD_CYC(HOLD_CYC),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk),
      .irstn(irstn),
      .sw_rst_req(sw_rst_req),
      .dom_ack(dom_ack),
      .dom_rstn(dom_rstn),
      .all_ready(all_ready),
      .fault(fault),
      .fault_idx(fault_idx),
      .state_o(state_o)
   );

   // Acks either follow the released resets (optionally masked) or are
   // driven directly.
   assign dom_ack = loopback ? (dom_rstn & ack_and) : ack_val;

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Count rising edges so expectations can be tagged by edge number.
   always @(posedge clk) edge_num <= edge_num + 1;

   task automatic push_expect(input int e, input logic [2:0] r, input logic ar,
                              input logic f, input logic [1:0] fi,
                              input logic [1:0] st, input string nm);
      exp_t x;
      x.edge_n = e;
      x.vec    = {r, ar, f, fi, st};
      x.name   = nm;
      exp_q.push_back(x);
   endtask

   task automatic checkOutput(input exp_t x, input logic [8:0] act);
      logic [8:0] want;
      want = x.vec;
      checks++;
      if (act === want) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s edge %0d: got rstn=%b ready=%b fault=%b idx=%0d state=%0d, expected rstn=%b ready=%b fault=%b idx=%0d state=%0d",
                  x.name, x.edge_n, act[8:6], act[5], act[4], act[3:2], act[1:0],
                  want[8:6], want[5], want[4], want[3:2], want[1:0]);
      end
   endtask

   // Monitor: compare every expectation whose edge has arrived.
   always @(negedge clk) begin : monitor
      exp_t x;
      while (exp_q.size() > 0 && (flush_req || exp_q[0].edge_n <= edge_num)) begin
         x = exp_q.pop_front();
         if (x.edge_n != edge_num) begin
            checks++;
            $display("[TB] FAIL %s: expectation for edge %0d never compared (now edge %0d)",
                     x.name, x.edge_n, edge_num);
         end else begin
            checkOutput(x, {dom_rstn, all_ready, fault, fault_idx, state_o});
         end
      end
   end

   task automatic wait_until(input int e);
      while (edge_num < e) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic applyStimulus(input logic sw, input logic lb,
                                input logic [2:0] andm, input logic [2:0] val);
      @(posedge clk);
      #2;
      sw_rst_req = sw;
      loopback   = lb;
      ack_and    = andm;
      ack_val    = val;
   endtask

   // Expected edges of a normal loopback sequence starting from HOLD at base.
   task automatic expect_sequence(input int b, input string tag);
      push_expect(b + 1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, {tag, "_hold"});
      push_expect(b + 2, 3'b001, 1'b0, 1'b0, 2'd0, 2'd1, {tag, "_dom0"});
      push_expect(b + 3, 3'b011, 1'b0, 1'b0, 2'd0, 2'd1, {tag, "_dom1"});
      push_expect(b + 4, 3'b111, 1'b0, 1'b0, 2'd0, 2'd1, {tag, "_dom2"});
      push_expect(b + 5, 3'b111, 1'b1, 1'b0, 2'd0, 2'd2, {tag, "_run"});
   endtask

   initial begin : stimulus
      int b;
      int e;

      // Reset state while irstn is held low.
      push_expect(1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "reset_state");
      push_expect(2, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "reset_held");
      wait_until(2);

      // Normal loopback sequence.
      irstn = 1'b1;
      b = edge_num;
      expect_sequence(b, "s1");
      push_expect(b + 6, 3'b111, 1'b1, 1'b0, 2'd0, 2'd2, "s1_run_stay");
      wait_until(b + 6);

      // Software re-sequence from RUN.
      applyStimulus(1'b1, 1'b1, 3'b111, 3'b000);
      e = edge_num;
      push_expect(e + 1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "s3_sw_hold");
      applyStimulus(1'b0, 1'b1, 3'b111, 3'b000);
      b = e + 1;
      expect_sequence(b, "s3");
      wait_until(b + 5);

      // Two acks drop at once while running; lowest index is blamed.
      applyStimulus(1'b0, 1'b0, 3'b111, 3'b111);
      e = edge_num;
      push_expect(e + 1, 3'b111, 1'b1, 1'b0, 2'd0, 2'd2, "s4_manual_run");
      applyStimulus(1'b0, 1'b0, 3'b111, 3'b010);
      e = edge_num;
      push_expect(e + 1, 3'b000, 1'b0, 1'b1, 2'd0, 2'd3, "s4_fault_idx0");
      push_expect(e + 2, 3'b000, 1'b0, 1'b1, 2'd0, 2'd3, "s4_fault_stay");
      wait_until(e + 2);
      applyStimulus(1'b1, 1'b0, 3'b111, 3'b010);
      e = edge_num;
      push_expect(e + 1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "s4_sw_clear");

      // Domain 1 never acks: timeout fault on domain 1.
      applyStimulus(1'b0, 1'b1, 3'b101, 3'b000);
      b = e + 1;
      push_expect(b + 1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "s2_hold");
      push_expect(b + 2, 3'b001, 1'b0, 1'b0, 2'd0, 2'd1, "s2_dom0");
      push_expect(b + 3, 3'b011, 1'b0, 1'b0, 2'd0, 2'd1, "s2_idx1");
      push_expect(b + 7, 3'b011, 1'b0, 1'b0, 2'd0, 2'd1, "s2_last_wait");
      push_expect(b + 8, 3'b000, 1'b0, 1'b1, 2'd1, 2'd3, "s2_timeout_fault");
      push_expect(b + 28, 3'b000, 1'b0, 1'b1, 2'd1, 2'd3, "s2_fault_sticky");
      wait_until(b + 28);

      // Clear, then drop irstn asynchronously while waiting on domain 1.
      applyStimulus(1'b1, 1'b1, 3'b101, 3'b000);
      e = edge_num;
      push_expect(e + 1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "s5_sw_clear");
      applyStimulus(1'b0, 1'b1, 3'b101, 3'b000);
      b = e + 1;
      push_expect(b + 2, 3'b001, 1'b0, 1'b0, 2'd0, 2'd1, "s5_dom0");
      push_expect(b + 3, 3'b011, 1'b0, 1'b0, 2'd0, 2'd1, "s5_idx1");
      wait_until(b + 4);
      irstn = 1'b0;
      push_expect(edge_num, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "s5_async_clear");
      push_expect(edge_num + 1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "s5_held");
      wait_until(edge_num + 2);
      ack_and = 3'b111;
      irstn = 1'b1;
      b = edge_num;
      expect_sequence(b, "s5_restart");
      wait_until(b + 5);

      // Software request on the same edge the final ack first arrives.
      applyStimulus(1'b1, 1'b1, 3'b111, 3'b000);
      e = edge_num;
      push_expect(e + 1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "s6_sw_hold");
      applyStimulus(1'b0, 1'b1, 3'b111, 3'b000);
      b = e + 1;
      push_expect(b + 2, 3'b001, 1'b0, 1'b0, 2'd0, 2'd1, "s6_dom0");
      push_expect(b + 4, 3'b111, 1'b0, 1'b0, 2'd0, 2'd1, "s6_dom2");
      wait_until(b + 4);
      sw_rst_req = 1'b1;
      push_expect(b + 5, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "s6_sw_beats_ack");
      push_expect(b + 6, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0, "s6_no_run");
      wait_until(b + 5);
      sw_rst_req = 1'b0;
      push_expect(b + 7, 3'b001, 1'b0, 1'b0, 2'd0, 2'd1, "s6_resequence");
      wait_until(b + 8);

      // Anything left over is reported by the monitor on its next pass.
      flush_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Safety net in case the stimulus never completes.
   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
